// File: rtl/approx_wallace_mac_pipe.sv
// approx_wallace_mac_pipe
//   Pipelined unsigned WIDTH x WIDTH multiply-accumulate with a per-beat
//   choice between the exact product and an approximate product whose low
//   APPROX_COLS columns are replaced by the OR of their partial-product bits.
//   Products are summed into an ACC_W accumulator over frames closed by
//   in_last; each frame result is offered on a valid/ready output.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (in_ready = ~stall)
//   a_in, b_in          unsigned operands
//   approx_en           1 = approximate product for this beat
//   in_last             beat closes the current frame
//   out_valid/out_ready frame result handshake
//   acc_out             frame sum modulo 2^ACC_W
//   ovf                 a carry out of bit ACC_W-1 occurred during the frame
//
// Pipeline: operand register -> PIPE tree registers -> accumulator.
// Everything freezes while a result is held back by out_ready=0.
module approx_wallace_mac_pipe #(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 4,
   parameter int PIPE        = 2,
   parameter int ACC_W       = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             approx_en,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   localparam int PW = 2 * WIDTH;
   // Columns below APPROX_COLS; wraps to all ones when APPROX_COLS = PW.
   localparam logic [PW-1:0] LOW_MASK = PW'((65'd1 << APPROX_COLS) - 65'd1);

   logic             stall;
   logic             op_v, op_approx, op_last;
   logic [WIDTH-1:0] op_a, op_b;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_v      <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_approx <= 1'b0;
         op_last   <= 1'b0;
      end else if (!stall) begin
         op_v <= in_valid;
         if (in_valid) begin
            op_a      <= a_in;
            op_b      <= b_in;
            op_approx <= approx_en;
            op_last   <= in_last;
         end
      end
   end

   // Partial-product rows folded through 3:2 carry-save compressors, one
   // final carry-propagate add. In approximate mode the low columns are
   // stripped from every row before compression so no carry can originate
   // below APPROX_COLS; those columns are rebuilt as a per-column OR.
   logic [PW-1:0] row, cs_s, cs_c, t_s, low_or, prod_c;
   logic          b_bit;

   always_comb begin
      row    = '0;
      cs_s   = '0;
      cs_c   = '0;
      t_s    = '0;
      low_or = '0;
      b_bit  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         b_bit = |(op_b & (WIDTH'(1) << i));
         row   = PW'(op_a & {WIDTH{b_bit}}) << i;
         if (op_approx) begin
            low_or = low_or | (row & LOW_MASK);
            row    = row & ~LOW_MASK;
         end
         t_s  = cs_s ^ cs_c ^ row;
         cs_c = ((cs_s & cs_c) | (cs_s & row) | (cs_c & row)) << 1;
         cs_s = t_s;
      end
      prod_c = (cs_s + cs_c) | low_or;
   end

   logic [PW-1:0] tail_p;
   logic          tail_v, tail_l;

   generate
      if (PIPE == 0) begin : g_comb
         assign tail_p = prod_c;
         assign tail_v = op_v;
         assign tail_l = op_last;
      end else begin : g_pipe
         logic [PIPE*PW-1:0] p_q;
         logic [PIPE-1:0]    v_q, l_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               p_q <= '0;
               v_q <= '0;
               l_q <= '0;
            end else if (!stall) begin
               p_q <= (p_q << PW) | (PIPE*PW)'(prod_c);
               v_q <= (v_q << 1) | PIPE'(op_v);
               l_q <= (l_q << 1) | PIPE'(op_last);
            end
         end

         assign tail_p = p_q[PIPE*PW-1 -: PW];
         assign tail_v = v_q[PIPE-1];
         assign tail_l = l_q[PIPE-1];
      end
   endgenerate

   logic [ACC_W-1:0] acc;
   logic             fresh, ovf_int, ovf_new;
   logic [ACC_W:0]   p_ext, sum_w;

   always_comb begin
      p_ext   = (ACC_W+1)'(tail_p);
      sum_w   = p_ext;
      ovf_new = 1'b0;
      if (!fresh) begin
         sum_w   = {1'b0, acc} + p_ext;
         ovf_new = ovf_int | sum_w[ACC_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         fresh     <= 1'b1;
         ovf_int   <= 1'b0;
         acc_out   <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         if (tail_v) begin
            acc     <= sum_w[ACC_W-1:0];
            ovf_int <= ovf_new;
            fresh   <= tail_l;
         end
         // Not stalled implies any held result is being taken this edge.
         if (tail_v && tail_l) begin
            acc_out   <= sum_w[ACC_W-1:0];
            ovf       <= ovf_new;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_approx_wallace_mac_pipe.sv
module tb_approx_wallace_mac_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       approx_en = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] a_in = 8'd0;
   logic [7:0] b_in = 8'd0;

   logic        ir_d, ir_k, ir_w;
   logic        ov_d, ov_k, ov_w;
   logic        of_d, of_k, of_w;
   logic [23:0] acc_d, acc_k;
   logic [15:0] acc_w;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   approx_wallace_mac_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_d),
      .a_in(a_in), .b_in(b_in), .approx_en(approx_en), .in_last(in_last),
      .out_valid(ov_d), .out_ready(out_ready), .acc_out(acc_d), .ovf(of_d));

   approx_wallace_mac_pipe #(.APPROX_COLS(0)) dut_k0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_k),
      .a_in(a_in), .b_in(b_in), .approx_en(approx_en), .in_last(in_last),
      .out_valid(ov_k), .out_ready(out_ready), .acc_out(acc_k), .ovf(of_k));

   approx_wallace_mac_pipe #(.ACC_W(16)) dut_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w),
      .a_in(a_in), .b_in(b_in), .approx_en(approx_en), .in_last(in_last),
      .out_valid(ov_w), .out_ready(out_ready), .acc_out(acc_w), .ovf(of_w));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive a beat and hold it until in_ready shows it will be taken at the
   // next rising edge; returns at the negedge before that edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ap, input logic last);
      @(negedge clk);
      in_valid  = 1'b1;
      a_in      = a;
      b_in      = b;
      approx_en = ap;
      in_last   = last;
      for (int g = 0; g < 50 && !ir_d; g++) @(negedge clk);
      chk("send_accept", 32'(ir_d), 1);
   endtask

   task automatic stop_and_wait(input string tag);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int g = 0; g < 20 && !ov_d; g++) @(negedge clk);
      chk({tag, "_valid"}, 32'(ov_d), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(ir_d), 1);
      chk("rst_out_valid", 32'(ov_d), 0);
      chk("rst_acc_out", 32'(acc_d), 0);
      chk("rst_ovf", 32'(of_d), 0);
      rst_n = 1'b1;

      // exact 255x255, latency to E0+3
      send(8'd255, 8'd255, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("lat_e0", 32'(ov_d), 0);
      @(negedge clk);
      @(negedge clk);
      chk("lat_e2", 32'(ov_d), 0);
      @(negedge clk);
      chk("lat_e3", 32'(ov_d), 1);
      chk("exact255", 32'(acc_d), 65025);
      chk("exact255_ovf", 32'(of_d), 0);
      chk("exact255_k0", 32'(acc_k), 65025);
      chk("exact255_w16", 32'(acc_w), 65025);

      // approximate products
      send(8'd255, 8'd255, 1'b1, 1'b1);
      stop_and_wait("apx255");
      chk("apx255", 32'(acc_d), 64991);
      chk("apx255_k0", 32'(acc_k), 65025);

      send(8'd3, 8'd3, 1'b1, 1'b1);
      stop_and_wait("apx33");
      chk("apx33", 32'(acc_d), 7);
      chk("apx33_k0", 32'(acc_k), 9);

      // 3x5 result held by backpressure, partial frame in flight, then reset
      @(negedge clk);
      out_ready = 1'b0;
      send(8'd3, 8'd5, 1'b1, 1'b1);
      send(8'd5, 8'd5, 1'b0, 1'b0);
      send(8'd7, 8'd7, 1'b0, 1'b0);
      stop_and_wait("apx35");
      chk("apx35", 32'(acc_d), 15);
      chk("apx35_k0", 32'(acc_k), 15);
      chk("apx35_stall_in_ready", 32'(ir_d), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(ov_d), 0);
      chk("midrst_acc_out", 32'(acc_d), 0);
      chk("midrst_in_ready", 32'(ir_d), 1);
      chk("midrst_acc_k0", 32'(acc_k), 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;

      send(8'd2, 8'd3, 1'b0, 1'b1);
      stop_and_wait("post_rst");
      chk("post_rst", 32'(acc_d), 6);
      chk("post_rst_ovf", 32'(of_d), 0);

      // accumulate and wrap
      send(8'd200, 8'd200, 1'b0, 1'b0);
      send(8'd200, 8'd200, 1'b0, 1'b0);
      send(8'd200, 8'd200, 1'b0, 1'b0);
      send(8'd200, 8'd200, 1'b0, 1'b1);
      stop_and_wait("acc4");
      chk("acc4_w24", 32'(acc_d), 160000);
      chk("acc4_w24_ovf", 32'(of_d), 0);
      chk("acc4_w16", 32'(acc_w), 28928);
      chk("acc4_w16_ovf", 32'(of_w), 1);

      send(8'd1, 8'd1, 1'b0, 1'b1);
      stop_and_wait("one");
      chk("one_w16", 32'(acc_w), 1);
      chk("one_w16_ovf", 32'(of_w), 0);
      chk("one_w24", 32'(acc_d), 1);

      // backpressure with tokens in flight
      @(negedge clk);
      out_ready = 1'b0;
      send(8'd10, 8'd10, 1'b0, 1'b1);
      send(8'd2, 8'd2, 1'b0, 1'b0);
      send(8'd3, 8'd3, 1'b0, 1'b0);
      send(8'd4, 8'd4, 1'b0, 1'b1);
      @(negedge clk);
      a_in      = 8'd6;
      b_in      = 8'd6;
      approx_en = 1'b0;
      in_last   = 1'b1;
      chk("bp_valid", 32'(ov_d), 1);
      chk("bp_acc", 32'(acc_d), 100);
      chk("bp_in_ready", 32'(ir_d), 0);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("bp_hold_acc", 32'(acc_d), 100);
         chk("bp_hold_in_ready", 32'(ir_d), 0);
         chk("bp_hold_valid", 32'(ov_d), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("bp_r0_valid", 32'(ov_d), 0);
      @(negedge clk);
      chk("bp_r1_valid", 32'(ov_d), 0);
      @(negedge clk);
      chk("bp_r2_valid", 32'(ov_d), 1);
      chk("bp_frame_b", 32'(acc_d), 29);
      @(negedge clk);
      chk("bp_r3_valid", 32'(ov_d), 1);
      chk("bp_frame_c", 32'(acc_d), 36);
      @(negedge clk);
      chk("bp_r4_valid", 32'(ov_d), 0);

      // back-to-back single-beat frames
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         if (i >= 4 && i <= 9) begin
            chk("b2b_valid", 32'(ov_d), 1);
            chk("b2b_acc", 32'(acc_d), (i - 3) * (i - 3));
            chk("b2b_in_ready", 32'(ir_d), 1);
         end else if (i == 10) begin
            chk("b2b_end_valid", 32'(ov_d), 0);
         end
         if (i < 6) begin
            in_valid  = 1'b1;
            a_in      = 8'(i + 1);
            b_in      = 8'(i + 1);
            approx_en = 1'b0;
            in_last   = 1'b1;
         end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
